// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared constants, state type and one-hot helper for the priority encoder
package prio_enc_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int WIDTH_MAX = 16;
  typedef enum logic {S_IDLE, S_PRESENT} state_t;
  function automatic logic [WIDTH_MAX-1:0] idx2onehot(input logic [3:0] idx);
    return WIDTH_MAX'(1) << idx;
  endfunction
endpackage

// File: rtl/prio_enc_comb.sv
// prio_enc_comb: combinational highest-set-bit encoder with an any-bit-set flag
module prio_enc_comb #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);
  // later (higher) set bits overwrite earlier ones, so the highest wins
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) if (vec_i[i]) idx_o = IDX_W'(i);
    any_o = |vec_i;
  end
endmodule

// File: rtl/prio_enc83_latch.sv
// prio_enc83_latch: latches request pulses and presents the highest pending line over VALID/ACK
module prio_enc83_latch
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             G1,
  input  logic             G2A,
  input  logic             G2B,
  input  logic [WIDTH-1:0] REQ,
  input  logic             ACK,
  output logic [IDX_W-1:0] CODE,
  output logic             VALID,
  output logic [WIDTH-1:0] PEND,
  output logic             OVR
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d, req_v, clr;
  logic [IDX_W-1:0] code_q, code_d, top_idx;
  logic             ovr_q, ovr_d, en, any_pend, take;
  prio_enc_comb #(.WIDTH(WIDTH)) u_enc (
    .vec_i(pend_q),
    .idx_o(top_idx),
    .any_o(any_pend)
  );
  // next-state: new requests beat the ACK clear, so a re-request keeps the line pending
  always_comb begin
    en      = G1 & G2A & G2B;
    req_v   = en ? REQ : '0;
    clr     = (state_q == S_PRESENT && ACK) ? WIDTH'(idx2onehot(4'(code_q))) : '0;
    pend_d  = (pend_q & ~clr) | req_v;
    ovr_d   = |(req_v & pend_q & ~clr);
    take    = (state_q == S_IDLE) && en && any_pend;
    state_d = (state_q == S_IDLE) ? (take ? S_PRESENT : S_IDLE) : (ACK ? S_IDLE : S_PRESENT);
    code_d  = take ? top_idx : code_q;
  end
  // state registers, cleared asynchronously so an in-flight handshake is discarded
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      code_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
    end
  end
  assign CODE  = code_q;
  assign VALID = (state_q == S_PRESENT);
  assign PEND  = pend_q;
  assign OVR   = ovr_q;
endmodule

// File: tb/tb_prio_enc83_latch.sv
// tb_prio_enc83_latch: directed and random checks of the latching priority encoder against a reference model
module tb_prio_enc83_latch;
  logic       clk = 1'b0;
  logic       rst_n, g1, g2a, g2b, ack;
  logic [7:0] req;
  logic [2:0] code;
  logic       valid, ovr;
  logic [7:0] pend;
  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] m_pend;
  logic       m_valid, m_ovr;
  int         m_code;

  prio_enc83_latch dut (
    .CLK(clk), .RST_N(rst_n), .G1(g1), .G2A(g2a), .G2B(g2b),
    .REQ(req), .ACK(ack), .CODE(code), .VALID(valid), .PEND(pend), .OVR(ovr)
  );

  always #5 clk = ~clk;

  function automatic int highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_code = 0;
  endtask

  // one clock of the spec's behaviour, computed from the inputs seen at this edge
  task automatic model_step();
    logic       en;
    logic [7:0] r, c;
    en = g1 & g2a & g2b;
    r = en ? req : 8'h00;
    c = (m_valid && ack) ? 8'(2 ** m_code) : 8'h00;
    m_ovr = (r & m_pend & ~c) != 0;
    if (!m_valid) begin
      if (en && m_pend != 0) begin
        m_valid = 1'b1;
        m_code = highest(m_pend);
      end
    end else if (ack) m_valid = 1'b0;
    m_pend = (m_pend & ~c) | r;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".VALID"}, {7'd0, valid}, {7'd0, m_valid});
    chk({tag, ".CODE"}, {5'd0, code}, 8'(m_code));
    chk({tag, ".PEND"}, pend, m_pend);
    chk({tag, ".OVR"}, {7'd0, ovr}, {7'd0, m_ovr});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  initial begin
    rst_n = 1'b0; g1 = 1'b0; g2a = 1'b0; g2b = 1'b0; ack = 1'b0; req = 8'h00;
    model_reset();
    #12;
    check_model("reset");
    rst_n = 1'b1;
    g1 = 1'b1; g2a = 1'b1; g2b = 1'b1;
    for (int i = 0; i < 10; i++) tick("idle");
    chk("idle_pend", pend, 8'h00);
    // two lines at once with ACK held: 5 first, one bubble, then 2
    ack = 1'b1; req = 8'h24;
    tick("r24_t0");
    req = 8'h00;
    chk("r24_no_valid_yet", {7'd0, valid}, 8'h00);
    tick("r24_t1");
    chk("r24_code5", {4'd0, valid, code}, 8'h0D);
    tick("r24_bubble");
    chk("r24_bubble_valid", {7'd0, valid}, 8'h00);
    tick("r24_t3");
    chk("r24_code2", {4'd0, valid, code}, 8'h0A);
    tick("r24_t4");
    chk("r24_final_pend", pend, 8'h00);
    // held code while higher request arrives
    ack = 1'b0; req = 8'h01;
    tick("r01");
    req = 8'h00;
    for (int i = 0; i < 21; i++) tick("hold0");
    chk("hold0_code", {4'd0, valid, code}, 8'h08);
    req = 8'h80;
    tick("r80");
    req = 8'h00;
    chk("r80_pend", pend, 8'h81);
    chk("r80_code_held", {5'd0, code}, 8'h00);
    ack = 1'b1;
    tick("ack0");
    tick("pres7");
    chk("next_code7", {4'd0, valid, code}, 8'h0F);
    tick("ack7");
    ack = 1'b0;
    // overrun on a second request to pending line 4, then re-request during ACK
    req = 8'h10;
    tick("r10a");
    chk("ovr_first", {7'd0, ovr}, 8'h00);
    req = 8'h00;
    tick("pres4");
    req = 8'h10;
    tick("r10b");
    chk("ovr_second", {7'd0, ovr}, 8'h01);
    req = 8'h00;
    tick("ovr_drop");
    chk("ovr_one_cycle", {7'd0, ovr}, 8'h00);
    req = 8'h10; ack = 1'b1;
    tick("r10_ack");
    chk("set_wins_pend", pend, 8'h10);
    req = 8'h00; ack = 1'b0;
    tick("re_pres4");
    chk("re_code4", {4'd0, valid, code}, 8'h0C);
    ack = 1'b1;
    tick("ack4");
    ack = 1'b0;
    // disabled capture, and enable drop while presenting
    g2b = 1'b0; req = 8'hFF;
    tick("dis_ff");
    req = 8'h00;
    tick("dis_1");
    chk("dis_pend", pend, 8'h00);
    chk("dis_valid", {7'd0, valid}, 8'h00);
    g2b = 1'b1; req = 8'h08;
    tick("r08");
    req = 8'h00;
    tick("pres3");
    g1 = 1'b0;
    for (int i = 0; i < 3; i++) tick("g1_low");
    chk("g1_low_valid", {7'd0, valid}, 8'h01);
    ack = 1'b1;
    tick("ack3_g1_low");
    chk("ack3_valid", {7'd0, valid}, 8'h00);
    g1 = 1'b1; ack = 1'b0;
    // asynchronous reset mid-handshake
    req = 8'h0C;
    tick("r0c");
    req = 8'h00;
    tick("pres_c");
    chk("pre_rst_pend", pend, 8'h0C);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick("post_rst");
    // random traffic
    for (int i = 0; i < 400; i++) begin
      g1 = ($urandom_range(0, 9) != 0);
      g2a = ($urandom_range(0, 9) != 0);
      g2b = ($urandom_range(0, 9) != 0);
      req = 8'($urandom) & 8'($urandom) & 8'($urandom);
      ack = ($urandom_range(0, 2) != 0);
      tick("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
